// File: rtl/sync_fifo_pkg.sv
// Shared pointer arithmetic for the synchronous FIFO read and write controllers.
// Pointers are {wrap, addr} with addr in 0..DEPTH-1, so DEPTH need not be a power of two.
package sync_fifo_pkg;

  localparam int unsigned CALC_W = 32;

  function automatic logic [CALC_W-1:0] ptr_add(input logic [CALC_W-1:0] ptr,
                                                input logic [CALC_W-1:0] k,
                                                input int unsigned       depth);
    int unsigned       aw;
    logic [CALC_W-1:0] addr;
    logic [CALC_W-1:0] wrap;
    logic [CALC_W-1:0] sum;
    aw   = $clog2(depth);
    addr = ptr & ((32'd1 << aw) - 32'd1);
    wrap = (ptr >> aw) & 32'd1;
    sum  = addr + k;
    // k never exceeds depth, so a single subtraction restores the range
    if (sum >= depth) begin
      sum  = sum - depth;
      wrap = wrap ^ 32'd1;
    end
    return (wrap << aw) | sum;
  endfunction

  function automatic logic [CALC_W-1:0] ptr_occ(input logic [CALC_W-1:0] w,
                                                input logic [CALC_W-1:0] r,
                                                input int unsigned       depth);
    int unsigned       aw;
    logic [CALC_W-1:0] mask;
    aw   = $clog2(depth);
    mask = (32'd1 << aw) - 32'd1;
    if (((w >> aw) & 32'd1) == ((r >> aw) & 32'd1))
      return (w & mask) - (r & mask);
    else
      return depth - (r & mask) + (w & mask);
  endfunction

endpackage

// File: rtl/sync_fifo_ptr_reg.sv
// {wrap, addr} pointer register with load (flush) and modular increment.
// Shared between the read and write controllers.
module sync_fifo_ptr_reg
  import sync_fifo_pkg::*;
#(
  parameter  int unsigned DEPTH = 16,
  parameter  int unsigned IW    = 1,
  localparam int unsigned PW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load_i,
  input  logic [PW-1:0] load_ptr_i,
  input  logic [IW-1:0] inc_i,
  output logic [PW-1:0] ptr_o
);

  logic [PW-1:0] ptr_q;
  logic [PW-1:0] ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (load_i)
      ptr_d = load_ptr_i;
    else
      ptr_d = PW'(ptr_add(32'(ptr_q), 32'(inc_i), DEPTH));
  end

  always_ff @(posedge clk) begin
    if (!rst_n)
      ptr_q <= '0;
    else
      ptr_q <= ptr_d;
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/sync_fifo_rd_ctrl.sv
// Read-side pointer controller: multi-pop grant clamp, flush, occupancy flags
// and a sticky underflow error around a shared pointer register.
module sync_fifo_rd_ctrl
  import sync_fifo_pkg::*;
#(
  parameter  int unsigned DEPTH     = 16,
  parameter  int unsigned MAX_POP   = 1,
  parameter  int unsigned AE_THRESH = 1,
  localparam int unsigned AW        = $clog2(DEPTH),
  localparam int unsigned PW        = AW + 1,
  localparam int unsigned CW        = $clog2(DEPTH + 1),
  localparam int unsigned NW        = $clog2(MAX_POP + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ren,
  input  logic [NW-1:0] rcount,
  input  logic          flush,
  input  logic          clr_err,
  input  logic [PW-1:0] w_ptr,
  output logic [PW-1:0] r_ptr,
  output logic [AW-1:0] r_addr,
  output logic [NW-1:0] pop_cnt,
  output logic [CW-1:0] occupancy,
  output logic          empty,
  output logic          almost_empty,
  output logic          underflow
);

  logic [NW-1:0]     rcount_c;
  logic [NW-1:0]     req;
  logic [CALC_W-1:0] occ_w;
  logic              short;
  logic              uf_set;
  logic              underflow_q;
  logic              underflow_d;

  always_comb begin
    rcount_c = rcount;
    if (32'(rcount) > MAX_POP)
      rcount_c = NW'(MAX_POP);
    req    = ren ? rcount_c : '0;
    occ_w  = ptr_occ(32'(w_ptr), 32'(r_ptr), DEPTH);
    short  = 32'(req) > occ_w;
    // A flush discards everything, so it neither pops nor can underflow
    pop_cnt = '0;
    if (!flush)
      pop_cnt = short ? NW'(occ_w) : req;
    uf_set = !flush && short;
  end

  sync_fifo_ptr_reg #(
    .DEPTH (DEPTH),
    .IW    (NW)
  ) u_rptr (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (flush),
    .load_ptr_i (w_ptr),
    .inc_i      (pop_cnt),
    .ptr_o      (r_ptr)
  );

  always_comb begin
    underflow_d = underflow_q;
    if (uf_set)
      underflow_d = 1'b1;
    else if (clr_err)
      underflow_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n)
      underflow_q <= 1'b0;
    else
      underflow_q <= underflow_d;
  end

  assign r_addr       = r_ptr[AW-1:0];
  assign occupancy    = CW'(occ_w);
  assign empty        = (w_ptr == r_ptr);
  assign almost_empty = (occ_w <= AE_THRESH);
  assign underflow    = underflow_q;

endmodule

// File: doc/sync_fifo_rd_ctrl.md
# sync_fifo_rd_ctrl

Read-side pointer controller for the systolic-array synchronous FIFOs. It generalises the single-pop read pointer in three ways: any depth (power of two not required), up to `MAX_POP` entries popped per cycle, and flush. It also reports occupancy, almost-empty and a sticky underflow error. It sits beside the FIFO storage array and its write-pointer controller, all in one clock domain, and drives the storage read address.

## Interface
Parameters:
- `DEPTH`, default 16: number of entries; any integer ≥ 2.
- `MAX_POP`, default 1: maximum pops per cycle; 1 ≤ `MAX_POP` ≤ `DEPTH`.
- `AE_THRESH`, default 1: `almost_empty` asserts when occupancy ≤ `AE_THRESH`; 0 ≤ `AE_THRESH` < `DEPTH`.
- Derived `AW` = $clog2(DEPTH); `PW` = `AW`+1; `CW` = $clog2(DEPTH+1); `NW` = $clog2(MAX_POP+1).

Ports:
- `clk`  in  1: the single clock.
- `rst_n`  in  1: synchronous, active-low reset.
- `ren`  in  1: pop request.
- `rcount`  in  `NW`: number of entries requested when `ren`=1.
- `flush`  in  1: discard all stored entries.
- `clr_err`  in  1: clear `underflow`.
- `w_ptr`  in  `PW`: write pointer `{wrap, addr}` from the write controller.
- `r_ptr`  out  `PW`: read pointer `{wrap, addr}`.
- `r_addr`  out  `AW`: storage read address, equal to `r_ptr[AW-1:0]`.
- `pop_cnt`  out  `NW`: entries actually popped this cycle (combinational).
- `occupancy`  out  `CW`: entries currently stored.
- `empty`  out  1: occupancy == 0.
- `almost_empty`  out  1: occupancy ≤ `AE_THRESH`.
- `underflow`  out  1: sticky error flag.

## Operation
- **Pointer format:**
  - `addr` runs 0..`DEPTH`-1.
  - `wrap` toggles each time `addr` passes `DEPTH`-1 → 0.
  - Increment by k: if `addr`+k ≥ `DEPTH`, then `addr` ← `addr`+k−`DEPTH` and `wrap` is toggled. Otherwise `addr` ← `addr`+k.
- **Occupancy** (combinational from current `w_ptr` and `r_ptr`):
  - Equal wrap bits: `w.addr` − `r.addr`.
  - Differing wrap bits: `DEPTH` − `r.addr` + `w.addr`.
  - Intermediate arithmetic is `CW`+1 bits wide, with no truncation before the final result.
- **Flags:** `empty` is (`w_ptr` == `r_ptr`). `almost_empty` is derived from occupancy. Both are combinational.
- **Grant:**
  - `req` = `ren` ? `rcount` : 0.
  - `pop_cnt` = `flush` ? 0 : min(`req`, occupancy).
- **Next pointer:**
  - `flush` → `r_ptr` ← `w_ptr`.
  - Otherwise `r_ptr` ← `r_ptr` + `pop_cnt`.
- **Underflow:**
  - Set when `flush`=0 and `req` > occupancy. The pointer still advances by the clamped `pop_cnt`.
  - Cleared by `clr_err`. If set and clear occur in the same cycle, set wins.
- **Values outside range:**
  - `rcount` > `MAX_POP` is treated as `MAX_POP` (clamped before the grant).
  - A `w_ptr` that would imply occupancy > `DEPTH` is illegal input; behaviour is undefined and the bench asserts it never occurs.

## Timing
- All state updates on posedge `clk`. There are no state machines beyond the pointer and the error flag.
- Reset (`rst_n`=0 at an edge):
  - `r_ptr` ← 0 and `underflow` ← 0.
  - Reset has priority over `flush`, `ren` and `clr_err`.
  - Mid-operation reset discards in-flight pops. The write side is reset in the same cycle by the parent.
- Output values after reset with `w_ptr`=0: `r_addr`=0, `pop_cnt`=0, `occupancy`=0, `empty`=1, `almost_empty`=1, `underflow`=0.
- Pop latency:
  - The entry at `r_addr` is presented to storage in the same cycle as `ren`.
  - `r_ptr` reflects the pop on the next cycle.
  - `pop_cnt` is valid combinationally in the cycle of the request.
- A write landing in cycle t is visible to the read side only through `w_ptr` in cycle t+1. There is no same-cycle write-to-read bypass, so a pop of an entry being written that cycle is not granted.
- Wrap-around: for `DEPTH` not a power of two, `addr` never takes values ≥ `DEPTH`.

## Structure
- Package `sync_fifo_pkg`:
  - Function `ptr_add(ptr, k, DEPTH)`, the modular increment with wrap toggle.
  - Function `ptr_occ(w, r, DEPTH)`.
  - Shared with `sync_fifo_wr_ctrl` so both sides use identical pointer arithmetic.
- One sub-module: `sync_fifo_ptr_reg`. It holds the pointer register with synchronous active-low reset, a load port (used for flush) and an increment port. It is reused by the write controller.
- This module is the glue around `sync_fifo_ptr_reg`: grant clamp, flags and the error flag.

## Test plan
Configuration for all scenarios: `DEPTH`=6, `MAX_POP`=2, `AE_THRESH`=1.
- **Reset:** hold `rst_n`=0 for 2 cycles with `ren`=1, `rcount`=2 and `w_ptr`=`{0,3}`.
  - `r_ptr`=0 after release.
  - `underflow`=0 after release.
- **Multi-pop and wrap:** `r_ptr`=`{0,5}`, `w_ptr`=`{1,3}` (occupancy 4); pop 2.
  - `pop_cnt`=2.
  - Next `r_ptr`=`{1,1}`, occupancy 2, `almost_empty`=0.
- **Underflow clamp:** occupancy 1, `ren`=1, `rcount`=2.
  - `pop_cnt`=1.
  - `empty`=1 next cycle.
  - `underflow`=1, held until `clr_err`.
- **Flush priority:** occupancy 4, `flush`=1 together with `ren`, `rcount`=2.
  - `pop_cnt`=0.
  - Next `r_ptr`=`w_ptr`, `empty`=1.
  - `underflow` unchanged.
- **Set/clear collision:** `underflow`=1, then `clr_err`=1 in the same cycle as a new underflow → `underflow` stays 1. `clr_err` alone → 0.
- **Random soak:** 10k cycles of random pops and writes against a reference queue model.
  - `occupancy` matches the model every cycle.
  - `empty` and `almost_empty` match the model every cycle.
  - `r_addr` stays < 6.
